// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the CPU control unit)
// and the mul/div sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// EX-stage request/result bundle for alu_muldiv.
//   master: pipeline side (drives start/alu_ctrl/input1/input2)
//   slave : ALU side (drives alu_result/zero/overflow/hi/lo/busy/done/div_zero)
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, alu_ctrl, input1, input2,
    input  alu_result, zero, overflow, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, alu_ctrl, input1, input2,
    output alu_result, zero, overflow, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath: operand magnitudes, radix-2
// shift-add / restoring shift-subtract, step counter and final sign fix.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_load          latch operands (i_div/i_signed/i_a/i_b)
//   i_step          perform one iteration
//   o_last          counter has reached the final step
//   o_hi, o_lo      sign-corrected HI/LO, valid after the last step
module muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  // r_acc is {product} for mul, {remainder, quotient/dividend} for div
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_dz, r_neg_q, r_neg_r;

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_add, w_try, w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_q, w_r;

  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -i_a : i_a;
  assign w_mag_b = w_b_neg ? -i_b : i_b;

  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

  // remainder < divisor, so the shifted partial remainder fits in WIDTH+1 bits;
  // bit WIDTH of the difference is the borrow
  assign w_try      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_try - {1'b0, r_m};
  assign w_div_next = w_diff[WIDTH] ? {w_try[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[2*WIDTH-1:WIDTH];
  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_dz) begin
      o_hi = w_r;
      o_lo = w_q;
    end else if (r_div) begin
      o_hi = r_neg_r ? -w_r : w_r;
      o_lo = r_neg_q ? -w_q : w_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_div   <= i_div;
      r_dz    <= i_div && (i_b == '0);
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (i_div && (i_b == '0)) begin
        // divide-by-zero result is preloaded: HI = dividend, LO = all ones
        r_acc <= {i_a, {WIDTH{1'b1}}};
        r_m   <= '0;
      end else if (i_div) begin
        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
        r_m   <= w_mag_b;
      end else begin
        r_acc <= {{WIDTH{1'b0}}, w_mag_b};
        r_m   <= w_mag_a;
      end
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU with single-cycle simple ops and iterative MULT/DIV into HI/LO.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  start/alu_ctrl/input1/input2 in; alu_result/zero/overflow,
//                hi/lo, busy/done/div_zero out
//
// state  | meaning
// S_IDLE | waiting for start; simple ops complete from here
// S_RUN  | one mul/div iteration per cycle
// S_FIX  | apply result signs, write HI/LO, pulse done next cycle
module alu_muldiv import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_zero, r_ovf, r_done, r_dz;

  logic             w_accept, w_md, w_div, w_dz_req, w_load, w_step, w_last, w_ovf;
  logic [WIDTH-1:0] w_sum, w_dif, w_res, w_hi, w_lo, w_a, w_b;

  assign w_a = bus.input1;
  assign w_b = bus.input2;

  // the cycle carrying done never accepts a new request
  assign w_accept = bus.start && (r_state == S_IDLE) && !r_done;
  assign w_md     = (bus.alu_ctrl[3:2] == 2'b10);
  assign w_div    = bus.alu_ctrl[1];
  assign w_dz_req = w_div && (w_b == '0);
  assign w_load   = w_accept && w_md;
  assign w_step   = (r_state == S_RUN);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_div    (w_div),
    .i_signed (!bus.alu_ctrl[0]),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_last   (w_last),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = w_dz_req ? S_FIX : S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sum = w_a + w_b;
  assign w_dif = w_a - w_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: w_res = w_a & w_b;
      ALU_OR:  w_res = w_a | w_b;
      ALU_NOR: w_res = ~(w_a | w_b);
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_dif;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);
      end
      // true signed compare; the SUB sign bit is wrong when SUB overflows
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_accept && !w_md) || (r_state == S_FIX);
      if (w_accept) r_dz <= w_md && w_dz_req;
      if (w_accept && !w_md) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
      end
      if (r_state == S_FIX) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end
    end
  end

  assign bus.alu_result = r_result;
  assign bus.zero       = r_zero;
  assign bus.overflow   = r_ovf;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.div_zero   = r_dz;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes predicted responses,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_muldiv;
  import alu_pkg::*;
  localparam int W = 32;
  localparam longint MAXP = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINN = -(longint'(1) <<< (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           busy_cyc;
    int           issue;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;

  // reference architectural state
  logic [W-1:0] m_res, m_hi, m_lo;
  logic         m_zero, m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic predict(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e);
    longint sa, sb_, s;
    logic [63:0] t;
    logic md;
    sa = $signed(a);
    sb_ = $signed(b);
    md = 1'b0;
    e.dz = 1'b0;
    e.lat = 1;
    e.busy_cyc = 0;
    case (ctrl)
      ALU_AND: begin m_res = a & b; m_ovf = 1'b0; end
      ALU_OR:  begin m_res = a | b; m_ovf = 1'b0; end
      ALU_NOR: begin m_res = ~(a | b); m_ovf = 1'b0; end
      ALU_ADD: begin s = sa + sb_; m_res = W'(s); m_ovf = (s > MAXP) || (s < MINN); end
      ALU_SUB: begin s = sa - sb_; m_res = W'(s); m_ovf = (s > MAXP) || (s < MINN); end
      ALU_SLT: begin m_res = (sa < sb_) ? 1 : 0; m_ovf = 1'b0; end
      ALU_MULT: begin md = 1'b1; t = sa * sb_; m_hi = t[63:32]; m_lo = t[31:0]; end
      ALU_MULTU: begin md = 1'b1; t = {32'd0, a} * {32'd0, b}; m_hi = t[63:32]; m_lo = t[31:0]; end
      ALU_DIV, ALU_DIVU: begin
        md = 1'b1;
        if (b == 0) begin
          m_hi = a; m_lo = '1; e.dz = 1'b1;
        end else if (ctrl == ALU_DIV) begin
          m_lo = W'(sa / sb_); m_hi = W'(sa % sb_);
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      default: begin m_res = '0; m_ovf = 1'b0; end
    endcase
    if (!md) m_zero = (m_res == 0);
    else if (e.dz) begin e.lat = 2; e.busy_cyc = 1; end
    else begin e.lat = W + 2; e.busy_cyc = W + 1; end
    e.res = m_res; e.zero = m_zero; e.ovf = m_ovf; e.hi = m_hi; e.lo = m_lo;
    e.issue = cyc;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt = 0;
    else if (bus.done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.issue), 64'(e.lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(e.busy_cyc));
        chk("busy_at_done", 64'(bus.busy), 64'(0));
        chk("alu_result", 64'(bus.alu_result), 64'(e.res));
        chk("zero", 64'(bus.zero), 64'(e.zero));
        chk("overflow", 64'(bus.overflow), 64'(e.ovf));
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("lo", 64'(bus.lo), 64'(e.lo));
        chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
      end
      busy_cnt = 0;
    end else if (bus.busy) busy_cnt++;
  end

  // caller is 1 time unit after a rising edge; returns likewise, start low
  task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.start = 1'b1; bus.alu_ctrl = ctrl; bus.input1 = a; bus.input2 = b;
    predict(ctrl, a, b, e);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.alu_ctrl = 4'($urandom); bus.input1 = $urandom; bus.input2 = $urandom;
  endtask

  task automatic junk_start();
    bus.start = 1'b1; bus.alu_ctrl = ALU_DIVU; bus.input1 = 32'd1000; bus.input2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); #1; t++; end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", t);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(ctrl, a, b);
    drain();
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] codes [12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR,
                               ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, 4'b0011, 4'b1111};
    logic [3:0] simple [6] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    m_res = '0; m_hi = '0; m_lo = '0; m_zero = 1'b0; m_ovf = 1'b0;
    bus.start = 1'b0; bus.alu_ctrl = '0; bus.input1 = '0; bus.input2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", 64'(bus.alu_result), 64'(0));
    chk("reset_hilo", {bus.hi, bus.lo}, 64'(0));
    chk("reset_flags", 64'({bus.zero, bus.overflow, bus.busy, bus.done, bus.div_zero}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (simple[i]) go(simple[i], 32'd128, 32'd128);
    go(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    go(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    go(ALU_SUB, 32'h8000_0000, 32'd1);
    go(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000);

    // MULT with ignored starts at cycle 10 (busy) and cycle 34 (done cycle)
    issue(ALU_MULT, -32'sd3, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    junk_start();
    repeat (23) @(posedge clk);
    #1;
    junk_start();
    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
    drain();

    go(ALU_DIV, -32'sd7, 32'd2);
    go(ALU_DIVU, 32'd100, 32'd7);
    go(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    go(ALU_DIV, 32'd5, 32'd0);

    // reset in cycle 15 of a DIV
    issue(ALU_DIV, -32'sd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_hilo", {bus.hi, bus.lo}, 64'(0));
    sb.delete();
    m_res = '0; m_hi = '0; m_lo = '0; m_zero = 1'b0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_done_hilo", {bus.hi, bus.lo}, 64'(0));
    go(ALU_DIVU, 32'd9, 32'd3);

    repeat (40) go(codes[$urandom_range(0, 11)], rnd_opnd(), rnd_opnd());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the single-cycle MIPS ALU.
- Keeps the same 4-bit ALU control codes for AND/OR/ADD/SUB/SLT and adds NOR, plus iterative MULT/MULTU/DIV/DIVU writing HI/LO registers.
- Sits in the EX stage; the pipeline stalls on busy and consumes results on done.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; samples alu_ctrl/input1/input2 when idle.
- alu_ctrl  in  4  operation code.
- input1  in  WIDTH  operand A (rs).
- input2  in  WIDTH  operand B (rt).
- alu_result  out  WIDTH  registered result of the last simple op.
- zero  out  1  alu_result == 0, registered with alu_result.
- overflow  out  1  signed overflow of ADD/SUB, else 0.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).
- busy  out  1  high while a mul/div is in flight.
- done  out  1  one-cycle pulse when a result/HI/LO is updated.
- div_zero  out  1  sticky until next start: last DIV/DIVU had input2 == 0.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, counter 0, internal accumulators 0. rst_n low mid-operation aborts it; no done is issued and HI/LO are cleared.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - Any other code: alu_result = 0, done still pulses.
- Simple ops: start in IDLE at cycle 0; alu_result/zero/overflow update and done = 1 in cycle 1; busy stays 0. HI/LO are unchanged.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. overflow = operand sign bits agree (ADD) / differ (SUB) and result sign differs from input1. SLT compares signed with full precision; it is not computed as a SUB sign bit.
- Mul/div FSM, IDLE -> RUN -> FIX -> IDLE:
  - IDLE + start + mul/div code: latch operand magnitudes (signed ops take abs values and record result signs), counter = 0, busy = 1, go to RUN.
  - RUN: one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle. After WIDTH steps (counter == WIDTH-1), go to FIX.
  - FIX: apply signs. Product is negated if signs differ. Quotient is negated if signs differ; remainder takes the sign of the dividend. Write HI/LO, pulse done, drop busy, go to IDLE.
  - Latency: start at cycle 0 -> done at cycle WIDTH+2. busy is high in cycles 1..WIDTH+1 and low in the done cycle.
- Divide by zero: skip RUN; FIX is entered in cycle 1 and done pulses in cycle 2. lo = all ones, hi = input1, div_zero = 1.
- Signed corner case: DIV of most-negative by -1 gives lo = most-negative, hi = 0, no trap.
- start while busy is ignored; no queueing, and operands are not re-sampled.
- start in the same cycle as done (FIX): ignored; a new start is accepted from the cycle after done.
- alu_result/zero/overflow hold their last values during mul/div. div_zero clears on any accepted start.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND/OR/ADD/SUB/SLT/NOR/MULT/MULTU/DIV/DIVU 4-bit localparams (the CPU control unit uses the same package);
  - FSM state encodings S_IDLE/S_RUN/S_FIX.
- One natural sub-module: muldiv_iter, holding the shift/accumulate datapath, counter and sign fix. The top level keeps the simple-op logic, FSM handshake and output registers.

Test Plan:
- Simple ops at WIDTH=32, input1 = input2 = 128, codes 0000/0001/0010/0110/0111/1100: alu_result = 128/128/256/0/0/0xFFFFFF7F; zero = 1 only for SUB and SLT; done one cycle after each start.
- ADD 0x7FFFFFFF + 1 -> alu_result = 0x80000000, overflow = 1. SLT input1 = 0xFFFFFFFF, input2 = 1 -> 1. SUB 0x80000000 - 1 -> overflow = 1.
- MULT -3 × 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done exactly 34 cycles after start, busy high for 33 cycles. MULTU 0xFFFFFFFF × 2 -> hi = 1, lo = 0xFFFFFFFE.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 -> lo = 14, hi = 2. DIV 5 / 0 -> lo = 0xFFFFFFFF, hi = 5, div_zero = 1, done at cycle 2.
- Second start pulsed at cycle 10 of a MULT: ignored, and HI/LO reflect only the first op. A start in the cycle after done is accepted.
- Assert rst_n low at cycle 15 of a DIV: busy = 0 and hi/lo = 0 immediately, no done pulse. A fresh DIVU 9 / 3 afterwards gives lo = 3, hi = 0.
